// File: rtl/button_press_generator.sv
// button_press_generator
//   Synthesises active-low push-button waveforms (short press, long press,
//   hold with N repeat ticks) from single commands, for board self-test and
//   loopback into the button-state detector.
//
//   Optional feature macro: BOUNCE_EN
//     defined   : every button transition is preceded by 3 bounce pulses of
//                 BOUNCE_TICKS at the target level then BOUNCE_TICKS at the
//                 previous level; steady durations start after the bounce.
//     undefined : clean single transitions, no bounce logic.
//
//   Ports
//     clk        in   system clock
//     reset      in   asynchronous active-low reset
//     cmd[1:0]   in   0 = no-op, 1 = short, 2 = long, 3 = hold
//     cmd_count  in   repeat ticks for hold (ignored otherwise)
//     cmd_valid  in   command request
//     cmd_ready  out  high only in IDLE
//     abort      in   terminate current command
//     button     out  generated button level, 1 = released
//     busy       out  high from acceptance until end of GAP
//     done       out  one-cycle pulse on the final GAP cycle
//     aborted    out  valid with done, 1 = command was aborted
module button_press_generator #(
    parameter logic [29:0] FREQ_CLK     = 30'd50_000_000,
    parameter logic [29:0] SHORT_TICKS  = FREQ_CLK / 30'd20,
    parameter logic [29:0] LONG_TICKS   = FREQ_CLK / 30'd2,
    parameter logic [29:0] GAP_TICKS    = FREQ_CLK / 30'd100,
    parameter logic [29:0] BOUNCE_TICKS = FREQ_CLK / 30'd20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_count,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       abort,
    output logic       button,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    localparam logic [29:0] REPEAT_TICKS = FREQ_CLK / 30'd10;
    localparam logic [29:0] TAIL_TICKS   = FREQ_CLK / 30'd20;

    // A zero duration would make a terminal count of all-ones and hang the FSM.
    if (SHORT_TICKS == '0 || LONG_TICKS == '0 || GAP_TICKS == '0 ||
        REPEAT_TICKS == '0 || TAIL_TICKS == '0 || BOUNCE_TICKS == '0) begin : g_bad_params
        $error("button_press_generator: every derived duration must be nonzero");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_REPEAT,
        S_TAIL,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] tc_q, tc_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [7:0]  count_q, count_d;
    logic        aborted_q, aborted_d;
    logic        button_q, button_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cmd_ready_q, cmd_ready_d;

    logic [29:0] press_ticks;
    logic        bouncing;
    logic        low_d;

`ifdef BOUNCE_EN
    // bidx counts remaining bounce half-pulses (6..1); even = target level,
    // odd = previous level. tc stays frozen at 0 while bidx is nonzero.
    logic [2:0]  bidx_q, bidx_d;
    logic [29:0] bt_q, bt_d;
`endif

    always_comb begin
        state_d   = state_q;
        tc_d      = tc_q + 30'd1;
        cmd_d     = cmd_q;
        count_d   = count_q;
        aborted_d = aborted_q;

        case (cmd_q)
            2'd1:    press_ticks = SHORT_TICKS;
            2'd2:    press_ticks = LONG_TICKS;
            default: press_ticks = FREQ_CLK;
        endcase

`ifdef BOUNCE_EN
        bidx_d   = bidx_q;
        bt_d     = bt_q;
        bouncing = (bidx_q != 3'd0);
        if (bouncing) begin
            if (bt_q == BOUNCE_TICKS - 30'd1) begin
                bt_d   = '0;
                bidx_d = bidx_q - 3'd1;
            end else begin
                bt_d = bt_q + 30'd1;
            end
        end
`else
        bouncing = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                tc_d = '0;
                if (cmd_valid) begin
                    cmd_d     = cmd;
                    count_d   = cmd_count;
                    aborted_d = 1'b0;
                    state_d   = (cmd == 2'd0) ? S_GAP : S_PRESS;
                end
            end
            S_PRESS: begin
                if (abort) begin
                    state_d   = S_GAP;
                    aborted_d = 1'b1;
                end else if (bouncing) begin
                    tc_d = tc_q;
                end else if (tc_q == press_ticks - 30'd1) begin
                    if (cmd_q != 2'd3)
                        state_d = S_GAP;
                    else if (count_q != 8'd0)
                        state_d = S_REPEAT;
                    else
                        state_d = S_TAIL;
                end
            end
            S_REPEAT: begin
                if (abort) begin
                    state_d   = S_GAP;
                    aborted_d = 1'b1;
                end else if (tc_q == REPEAT_TICKS - 30'd1) begin
                    // count is always nonzero here, so the decrement never wraps
                    count_d = count_q - 8'd1;
                    tc_d    = '0;
                    if (count_q == 8'd1)
                        state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                if (abort) begin
                    state_d   = S_GAP;
                    aborted_d = 1'b1;
                end else if (tc_q == TAIL_TICKS - 30'd1) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (bouncing)
                    tc_d = tc_q;
                else if (tc_q == GAP_TICKS - 30'd1)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q)
            tc_d = '0;

`ifdef BOUNCE_EN
        // Bounce only where the line actually changes level: IDLE->PRESS and
        // any low state -> GAP (a no-op command enters GAP already high).
        if (state_d != state_q &&
            ((state_d == S_PRESS && state_q == S_IDLE) ||
             (state_d == S_GAP && state_q != S_IDLE))) begin
            bidx_d = 3'd6;
            bt_d   = '0;
        end
`endif

        // Outputs are derived from the next state so they are registered
        // and line up with the state they describe.
        low_d       = (state_d == S_PRESS) || (state_d == S_REPEAT) || (state_d == S_TAIL);
        button_d    = ~low_d;
        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
        done_d      = (state_d == S_GAP) && (tc_d == GAP_TICKS - 30'd1);

`ifdef BOUNCE_EN
        if (bidx_d != 3'd0) begin
            button_d = (state_d == S_PRESS) ? bidx_d[0] : ~bidx_d[0];
            done_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tc_q        <= '0;
            cmd_q       <= '0;
            count_q     <= '0;
            aborted_q   <= 1'b0;
            button_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
`ifdef BOUNCE_EN
            bidx_q      <= '0;
            bt_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tc_q        <= tc_d;
            cmd_q       <= cmd_d;
            count_q     <= count_d;
            aborted_q   <= aborted_d;
            button_q    <= button_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef BOUNCE_EN
            bidx_q      <= bidx_d;
            bt_q        <= bt_d;
`endif
        end
    end

    assign button    = button_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_button_press_generator.sv
module tb_button_press_generator;

    logic       clk;
    logic       reset;
    logic [1:0] cmd;
    logic [7:0] cmd_count;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       abort;
    logic       button;
    logic       busy;
    logic       done;
    logic       aborted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   low;
        int   hi;
        logic ab;
    } exp_t;

    exp_t sb[$];
    int   low_cnt = 0;
    int   hi_cnt  = 0;

    button_press_generator #(
        .FREQ_CLK(30'd20_000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd),
        .cmd_count (cmd_count),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .abort     (abort),
        .button    (button),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one command; returns #1 after the acceptance edge.
    task automatic issue(input logic [1:0] c, input logic [7:0] n);
        cmd       = c;
        cmd_count = n;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        cmd       = 2'd0;
        cmd_count = 8'd0;
        check("accept_ready_low", int'(cmd_ready), 0);
        check("accept_busy_high", int'(busy), 1);
        check("accept_button", int'(button), (c == 2'd0) ? 1 : 0);
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check(tag, int'(got), 1);
        @(posedge clk);
        #1;
        check("post_done_ready", int'(cmd_ready), 1);
        check("post_done_busy", int'(busy), 0);
        check("post_done_pulse_width", int'(done), 0);
    endtask

    // Monitor: measures low time and high-until-done time of each command,
    // compares against the scoreboard entry pushed when it was issued.
    always @(negedge clk) begin
        if (!reset) begin
            low_cnt = 0;
            hi_cnt  = 0;
        end else begin
            if (busy) begin
                if (!button) low_cnt++;
                else         hi_cnt++;
            end
            if (done) begin
                check("sb_nonempty_at_done", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("low_len", low_cnt, e.low);
                    check("gap_len", hi_cnt, e.hi);
                    check("aborted_flag", int'(aborted), int'(e.ab));
                end
                low_cnt = 0;
                hi_cnt  = 0;
            end
        end
    end

    initial begin
        int lows;
        int dones;

        reset     = 1'b0;
        cmd       = 2'd0;
        cmd_count = 8'd0;
        cmd_valid = 1'b0;
        abort     = 1'b0;

        tick(3);
        check("rst_button", int'(button), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_aborted", int'(aborted), 0);
        check("rst_ready", int'(cmd_ready), 1);
        reset = 1'b1;
        tick(2);

        // short press
        sb.push_back('{1000, 200, 1'b0});
        issue(2'd1, 8'd0);
        wait_done(1300, "done_short");

        // long press
        sb.push_back('{10000, 200, 1'b0});
        issue(2'd2, 8'd0);
        wait_done(10500, "done_long");

        // hold with 4 repeat ticks: 20000 + 4*2000 + 1000
        sb.push_back('{29000, 200, 1'b0});
        issue(2'd3, 8'd4);
        wait_done(29500, "done_hold4");

        // hold with zero repeats: 20000 + 1000
        sb.push_back('{21000, 200, 1'b0});
        issue(2'd3, 8'd0);
        wait_done(21500, "done_hold0");

        // no-op: no low pulse, done after the gap
        sb.push_back('{0, 200, 1'b0});
        issue(2'd0, 8'd0);
        wait_done(300, "done_noop");

        // abort together with cmd_valid in IDLE is ignored; abort in GAP too
        sb.push_back('{1000, 200, 1'b0});
        abort = 1'b1;
        issue(2'd1, 8'd0);
        abort = 1'b0;
        tick(1009);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_done(400, "done_abort_ignored");

        // long press aborted in its 500th low cycle; stray requests while busy
        sb.push_back('{500, 200, 1'b1});
        issue(2'd2, 8'd0);
        tick(99);
        cmd       = 2'd1;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        tick(399);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_release", int'(button), 1);
        check("abort_still_busy", int'(busy), 1);
        tick(49);
        cmd       = 2'd2;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        cmd       = 2'd0;
        wait_done(400, "done_aborted");

        // asynchronous reset in the middle of a long press
        issue(2'd2, 8'd0);
        tick(299);
        reset = 1'b0;
        #1;
        check("async_rst_button", int'(button), 1);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_ready", int'(cmd_ready), 1);
        check("async_rst_done", int'(done), 0);
        #2;
        reset = 1'b1;
        lows  = 0;
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!button) lows++;
            if (done)    dones++;
        end
        check("post_rst_no_low", lows, 0);
        check("post_rst_no_done", dones, 0);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
